// File: rtl/seg_bus_pkg.sv
// Shared definitions for the 2-wire 7-segment display bus (driver and responder).
// Command codes, command-byte bit positions, responder states and segment codes.
package seg_bus_pkg;

    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    localparam int FIXED_ADDR_BIT = 2;
    localparam int DISP_ON_BIT    = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RX_BITS   = 2'd1,
        ACK       = 2'd2,
        WAIT_STOP = 2'd3
    } rsp_state_t;

    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;

endpackage

// File: rtl/seg_bus_sync.sv
// Synchronizes the bus lines into clk_i and detects SCL edges and START/STOP.
// An SCL edge takes priority; a coincident SDA edge is re-evaluated next cycle.
module seg_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic por_i,
    input  logic sync_reset_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_ff, sda_ff;
    logic scl_q, sda_q, scl_s, scl_edge;

    // Chains reset to the idle-high bus level so reset itself creates no edges.
    always_ff @(posedge clk_i or posedge por_i) begin
        if (por_i) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else if (sync_reset_i) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_i};
            sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_i};
            scl_q  <= scl_s;
            if (!scl_edge) sda_q <= sda_s;
        end
    end

    assign scl_s     = scl_ff[SYNC_STAGES-1];
    assign sda_s     = sda_ff[SYNC_STAGES-1];
    assign scl_edge  = scl_s ^ scl_q;
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = ~scl_edge & scl_s & sda_q & ~sda_s;
    assign stop_det  = ~scl_edge & scl_s & ~sda_q & sda_s;

endmodule

// File: rtl/seg_bus_responder.sv
// Display-side responder of the 2-wire segment bus: decodes command/address/data
// bytes, ACKs them, and commits digit and display-control registers at STOP.
module seg_bus_responder
    import seg_bus_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk_i,
    input  logic                       por_i,
    input  logic                       sync_reset_i,
    input  logic                       scl_i,
    input  logic                       sda_i,
    output logic                       sda_oe_o,
    output logic [NUM_DIGITS-1:0][7:0] digits_o,
    output logic                       disp_on_o,
    output logic [2:0]                 brightness_o,
    output logic                       frame_done_o,
    output logic                       cmd_err_o
);

    typedef struct packed {
        rsp_state_t                 state;
        logic [3:0]                 bit_cnt;
        logic [7:0]                 shift;
        logic                       first_byte;
        logic                       auto_inc;
        logic                       addr_frame;
        logic                       had_byte;
        logic                       ctrl_pend;
        logic                       pend_on;
        logic [2:0]                 pend_bri;
        logic [2:0]                 addr;
        logic [NUM_DIGITS-1:0][7:0] shadow;
        logic [NUM_DIGITS-1:0][7:0] digits;
        logic                       disp_on;
        logic [2:0]                 bri;
        logic                       frame_done;
        logic                       cmd_err;
        logic                       sda_oe;
    } regs_t;

    localparam regs_t R_RST = '{state: IDLE, first_byte: 1'b1, auto_inc: 1'b1, default: '0};

    regs_t r, r_nxt;
    logic  scl_rise, scl_fall, start_det, stop_det, sda_s;

    seg_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i        (clk_i),
        .por_i        (por_i),
        .sync_reset_i (sync_reset_i),
        .scl_i        (scl_i),
        .sda_i        (sda_i),
        .scl_rise     (scl_rise),
        .scl_fall     (scl_fall),
        .start_det    (start_det),
        .stop_det     (stop_det),
        .sda_s        (sda_s)
    );

    always_ff @(posedge clk_i or posedge por_i) begin
        if (por_i)             r <= R_RST;
        else if (sync_reset_i) r <= R_RST;
        else                   r <= r_nxt;
    end

    always_comb begin
        r_nxt            = r;
        r_nxt.frame_done = 1'b0;
        if (start_det) begin
            // Repeated START keeps shadow and pending control for the next STOP.
            r_nxt.state      = RX_BITS;
            r_nxt.sda_oe     = 1'b0;
            r_nxt.bit_cnt    = '0;
            r_nxt.first_byte = 1'b1;
        end else if (stop_det) begin
            r_nxt.state  = IDLE;
            r_nxt.sda_oe = 1'b0;
            if (r.had_byte) begin
                r_nxt.digits     = r.shadow;
                r_nxt.frame_done = 1'b1;
                if (r.ctrl_pend) begin
                    r_nxt.disp_on = r.pend_on;
                    r_nxt.bri     = r.pend_bri;
                end
            end
            r_nxt.had_byte   = 1'b0;
            r_nxt.ctrl_pend  = 1'b0;
            r_nxt.addr_frame = 1'b0;
        end else begin
            case (r.state)
                RX_BITS: begin
                    if (scl_rise && !r.bit_cnt[3]) begin
                        r_nxt.shift[r.bit_cnt[2:0]] = sda_s;
                        r_nxt.bit_cnt               = r.bit_cnt + 4'd1;
                    end
                    // ACK drive starts only after the 8th fall, so SDA never moves with SCL high.
                    if (scl_fall && r.bit_cnt == 4'd8) begin
                        r_nxt.state  = ACK;
                        r_nxt.sda_oe = 1'b1;
                    end
                end
                ACK: begin
                    if (scl_fall) begin
                        r_nxt.state      = RX_BITS;
                        r_nxt.sda_oe     = 1'b0;
                        r_nxt.bit_cnt    = '0;
                        r_nxt.first_byte = 1'b0;
                        r_nxt.had_byte   = 1'b1;
                        if (r.first_byte) begin
                            r_nxt.addr_frame = 1'b0;
                            case (r.shift[7:6])
                                CMD_DATA: begin
                                    r_nxt.auto_inc = ~r.shift[FIXED_ADDR_BIT];
                                    r_nxt.state    = WAIT_STOP;
                                end
                                CMD_ADDR: begin
                                    r_nxt.addr       = r.shift[2:0];
                                    r_nxt.addr_frame = 1'b1;
                                end
                                CMD_DISP: begin
                                    r_nxt.ctrl_pend = 1'b1;
                                    r_nxt.pend_on   = r.shift[DISP_ON_BIT];
                                    r_nxt.pend_bri  = r.shift[2:0];
                                end
                                default: begin
                                    r_nxt.cmd_err = 1'b1;
                                    r_nxt.state   = WAIT_STOP;
                                end
                            endcase
                        end else if (r.addr_frame) begin
                            for (int i = 0; i < NUM_DIGITS; i++)
                                if (int'(r.addr) == i) r_nxt.shadow[i] = r.shift;
                            if (r.auto_inc && r.addr != 3'd7) r_nxt.addr = r.addr + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe_o     = r.sda_oe;
    assign digits_o     = r.digits;
    assign disp_on_o    = r.disp_on;
    assign brightness_o = r.bri;
    assign frame_done_o = r.frame_done;
    assign cmd_err_o    = r.cmd_err;

endmodule
